// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence controller and round-robin arbiter sharing one RAM port among CPUS icache/dcache pairs.
// Optional macro CC_C2C_EN: forward a Modified block cache-to-cache instead of owner writeback + RAM refill.
module coherence_bus_ctrl #(
    parameter int CPUS   = 4,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS*ADDR_W-1:0]   ccsnoopaddr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic [3:0]               dbg_state,
    output logic [$clog2(CPUS)-1:0]  dbg_rr
);
    localparam int IW = $clog2(CPUS);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE, SNOOP, C2C0, C2C1, RD0, RD1, WB0, WB1, IFETCH
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr, rr_n, req, req_n, owner, owner_n;
    logic          req_write, req_write_n, snoop_txn, snoop_txn_n, owner_wb, owner_wb_n;
    logic          acc, word1, d_found, i_found, own_found;
    logic [IW-1:0] d_win, i_win, own_win, wb_cpu;
    int            arb_idx;
    logic          unused_dren;

    // A dREN without cctrans is a cache hit; the bus only acts on misses and writebacks.
    assign unused_dren = ^dREN;

    function automatic logic [ADDR_W-1:0] blk_addr(input logic [ADDR_W-1:0] a, input logic w1);
        return {a[ADDR_W-1:3], w1, 2'b00};
    endfunction

    assign acc       = (ramstate == RAM_ACCESS);
    assign word1     = (state == C2C1) || (state == RD1) || (state == WB1);
    assign wb_cpu    = owner_wb ? owner : req;
    assign dbg_state = state;
    assign dbg_rr    = rr;

    // Round-robin search from rr: data requests first, instruction fetches only when none.
    always_comb begin
        d_found = 1'b0; d_win = '0; i_found = 1'b0; i_win = '0; arb_idx = 0;
        for (int k = 0; k < CPUS; k++) begin
            arb_idx = (int'(rr) + k) % CPUS;
            if (!d_found && (cctrans[arb_idx] || dWEN[arb_idx])) begin
                d_found = 1'b1;
                d_win   = IW'(arb_idx);
            end
            if (!i_found && iREN[arb_idx]) begin
                i_found = 1'b1;
                i_win   = IW'(arb_idx);
            end
        end
    end

    always_comb begin
        own_found = 1'b0; own_win = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != int'(req) && ccwrite[j]) begin
                own_found = 1'b1;
                own_win   = IW'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE; rr <= '0; req <= '0; owner <= '0;
            req_write <= 1'b0; snoop_txn <= 1'b0; owner_wb <= 1'b0;
        end else begin
            state <= state_n; rr <= rr_n; req <= req_n; owner <= owner_n;
            req_write <= req_write_n; snoop_txn <= snoop_txn_n; owner_wb <= owner_wb_n;
        end
    end

    always_comb begin
        state_n = state; rr_n = rr; req_n = req; owner_n = owner;
        req_write_n = req_write; snoop_txn_n = snoop_txn; owner_wb_n = owner_wb;
        case (state)
            IDLE: begin
                if (d_found) begin
                    req_n      = d_win;
                    owner_wb_n = 1'b0;
                    if (cctrans[d_win]) begin
                        state_n     = SNOOP;
                        snoop_txn_n = 1'b1;
                        req_write_n = ccwrite[d_win];
                    end else begin
                        state_n = WB0;
                    end
                end else if (i_found) begin
                    req_n      = i_win;
                    owner_wb_n = 1'b0;
                    state_n    = IFETCH;
                end
            end
            SNOOP: begin
                if (own_found) begin
                    owner_n = own_win;
`ifdef CC_C2C_EN
                    state_n = C2C0;
`else
                    state_n    = WB0;
                    owner_wb_n = 1'b1;
`endif
                end else begin
                    state_n = RD0;
                end
            end
            C2C0: if (acc) state_n = C2C1;
            RD0:  if (acc) state_n = RD1;
            WB0:  if (acc) state_n = WB1;
            WB1: begin
                if (acc && owner_wb) begin
                    state_n    = RD0;
                    owner_wb_n = 1'b0;
                end else if (acc) begin
                    state_n = IDLE;
                end
            end
            C2C1, RD1, IFETCH: if (acc) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && state_n == IDLE) begin
            rr_n        = (int'(req) == CPUS - 1) ? '0 : req + 1'b1;
            snoop_txn_n = 1'b0;
        end
    end

    // Handshake: a *wait bit low for one cycle means one word moved; requests stay high until the last word.
    always_comb begin
        iwait = '1; dwait = '1; iload = '0; dload = '0;
        ccwait = '0; ccinv = '0; ccsnoopaddr = '0;
        ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
        if (snoop_txn) begin
            for (int j = 0; j < CPUS; j++) begin
                if (j != int'(req)) begin
                    ccwait[j] = 1'b1;
                    ccinv[j]  = (state == SNOOP) && req_write;
                    ccsnoopaddr[j*ADDR_W +: ADDR_W] = daddr[int'(req)*ADDR_W +: ADDR_W];
                end
            end
        end
        case (state)
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = blk_addr(daddr[int'(wb_cpu)*ADDR_W +: ADDR_W], word1);
                ramstore = dstore[int'(wb_cpu)*WORD_W +: WORD_W];
                if (acc) dwait[wb_cpu] = 1'b0;
            end
            C2C0, C2C1: begin
                ramWEN   = 1'b1;
                ramaddr  = blk_addr(daddr[int'(owner)*ADDR_W +: ADDR_W], word1);
                ramstore = dstore[int'(owner)*WORD_W +: WORD_W];
                dload[int'(req)*WORD_W +: WORD_W] = dstore[int'(owner)*WORD_W +: WORD_W];
                if (acc) begin
                    dwait[req]   = 1'b0;
                    dwait[owner] = 1'b0;
                end
            end
            RD0, RD1: begin
                ramREN  = 1'b1;
                ramaddr = blk_addr(daddr[int'(req)*ADDR_W +: ADDR_W], word1);
                dload[int'(req)*WORD_W +: WORD_W] = ramload;
                if (acc) dwait[req] = 1'b0;
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[int'(req)*ADDR_W +: ADDR_W];
                iload[int'(req)*WORD_W +: WORD_W] = ramload;
                if (acc) iwait[req] = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: RAM model, stimulus tasks, event scoreboard and summary.
module tb_coherence_bus_ctrl;
  localparam int CPUS = 4;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int EW = 2 + 3 + ADDR_W + WORD_W;
  localparam logic [1:0] K_RAMW = 2'd0, K_RAMR = 2'd1, K_DACK = 2'd2, K_IACK = 2'd3;
  localparam logic [3:0] S_IDLE = 4'd0, S_SNOOP = 4'd1, S_RD1 = 4'd5, S_WB0 = 4'd6, S_WB1 = 4'd7;

  logic CLK = 1'b0;
  logic nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, cctrans, ccwrite;
  logic [CPUS*ADDR_W-1:0] iaddr, daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
  logic [CPUS*WORD_W-1:0] iload, dload;
  logic [CPUS*ADDR_W-1:0] ccsnoopaddr;
  logic ramREN, ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore, ramload;
  logic [1:0] ramstate;
  logic [3:0] dbg_state;
  logic [1:0] dbg_rr;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [WORD_W-1:0] mem [0:1023];
  logic [1023:0] mem_v = '0;

  // clock / reset
  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.CPUS(CPUS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .dbg_state(dbg_state), .dbg_rr(dbg_rr)
  );

  // RAM: unwritten words read back as 0xA0000000 | address
  always @(posedge CLK) begin
    if (ramWEN && ramstate == 2'd2) begin
      mem[ramaddr[11:2]] <= ramstore;
      mem_v[ramaddr[11:2]] <= 1'b1;
    end
  end
  assign ramload = mem_v[ramaddr[11:2]] ? mem[ramaddr[11:2]] : (32'hA000_0000 | ramaddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input int c, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({k, 3'(c), a, d});
  endtask

  task automatic see(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d cpu=%0d addr=%h data=%h",
               got[EW-1 -: 2], got[EW-3 -: 3], got[63:32], got[31:0]);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL event actual kind=%0d cpu=%0d addr=%h data=%h required kind=%0d cpu=%0d addr=%h data=%h",
                 got[EW-1 -: 2], got[EW-3 -: 3], got[63:32], got[31:0],
                 e[EW-1 -: 2], e[EW-3 -: 3], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic monitor_cycle();
    checks++;
    if (ramREN && ramWEN) begin
      failures++;
      $display("FAIL ram_strobes actual=11 required=not_both");
    end
    if (ramWEN && ramstate == 2'd2) see({K_RAMW, 3'd0, ramaddr, ramstore});
    if (ramREN && ramstate == 2'd2) see({K_RAMR, 3'd0, ramaddr, ramload});
    for (int i = 0; i < CPUS; i++) begin
      if (!dwait[i]) see({K_DACK, 3'(i), 32'h0, dload[i*WORD_W +: WORD_W]});
      if (!iwait[i]) see({K_IACK, 3'(i), 32'h0, iload[i*WORD_W +: WORD_W]});
    end
  endtask

  task automatic set_daddr(input int c, input logic [31:0] a);
    daddr[c*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic set_dstore(input int c, input logic [31:0] d);
    dstore[c*WORD_W +: WORD_W] = d;
  endtask

  // Waits for n data acks to cpu; an owner cache switches to its second word after its first ack.
  task automatic wait_dacks(input int cpu, input int n, input int owner, input logic [31:0] own_w1);
    int got = 0;
    int own = 0;
    int cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (!dwait[cpu]) got++;
      if (owner >= 0 && !dwait[owner]) own++;
      @(posedge CLK);
      #1;
      if (owner >= 0 && own == 1) set_dstore(owner, own_w1);
    end
    chk("dack_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLK);
        monitor_cycle();
      end
    join_none

    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = 2'd2;

    // reset values
    @(negedge CLK);
    chk("reset_waits", 64'({iwait, dwait}), 64'hFF);
    chk("reset_cc", 64'({ccwait, ccinv}), 64'h0);
    chk("reset_ram", 64'({ramREN, ramWEN, ramaddr, ramstore} != '0), 64'h0);
    chk("reset_loads", 64'((|{iload, dload, ccsnoopaddr})), 64'h0);
    chk("reset_state", 64'({dbg_state, dbg_rr}), 64'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // read miss, no owner
    push_ev(K_RAMR, 0, 32'h100, 32'hA000_0100);
    push_ev(K_DACK, 2, 32'h0, 32'hA000_0100);
    push_ev(K_RAMR, 0, 32'h104, 32'hA000_0104);
    push_ev(K_DACK, 2, 32'h0, 32'hA000_0104);
    set_daddr(2, 32'h100);
    cctrans[2] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("t1_snoop_state", 64'(dbg_state), 64'(S_SNOOP));
    chk("t1_ccwait", 64'(ccwait), 64'b1011);
    chk("t1_ccinv", 64'(ccinv), 64'b0000);
    chk("t1_snoopaddr0", 64'(ccsnoopaddr[0 +: ADDR_W]), 64'h100);
    wait_dacks(2, 2, -1, 32'h0);
    cctrans = '0;
    chk("t1_rr", 64'(dbg_rr), 64'd3);
    chk("t1_idle", 64'(dbg_state), 64'(S_IDLE));

    // BusRdX with Modified owner CPU3
`ifdef CC_C2C_EN
    push_ev(K_RAMW, 0, 32'h200, 32'hDEAD_BEEF);
    push_ev(K_DACK, 0, 32'h0, 32'hDEAD_BEEF);
    push_ev(K_DACK, 3, 32'h0, 32'h0);
    push_ev(K_RAMW, 0, 32'h204, 32'hCAFE_F00D);
    push_ev(K_DACK, 0, 32'h0, 32'hCAFE_F00D);
    push_ev(K_DACK, 3, 32'h0, 32'h0);
`else
    push_ev(K_RAMW, 0, 32'h200, 32'hDEAD_BEEF);
    push_ev(K_DACK, 3, 32'h0, 32'h0);
    push_ev(K_RAMW, 0, 32'h204, 32'hCAFE_F00D);
    push_ev(K_DACK, 3, 32'h0, 32'h0);
    push_ev(K_RAMR, 0, 32'h200, 32'hDEAD_BEEF);
    push_ev(K_DACK, 0, 32'h0, 32'hDEAD_BEEF);
    push_ev(K_RAMR, 0, 32'h204, 32'hCAFE_F00D);
    push_ev(K_DACK, 0, 32'h0, 32'hCAFE_F00D);
`endif
    set_daddr(0, 32'h200);
    set_daddr(3, 32'h200);
    set_dstore(3, 32'hDEAD_BEEF);
    ccwrite = 4'b1001;
    cctrans[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("t2_ccwait", 64'(ccwait), 64'b1110);
    chk("t2_ccinv", 64'(ccinv), 64'b1110);
    wait_dacks(0, 2, 3, 32'hCAFE_F00D);
    cctrans = '0;
    ccwrite = '0;
    chk("t2_rr", 64'(dbg_rr), 64'd1);

    // eviction writeback with 3 BUSY cycles
    push_ev(K_RAMW, 0, 32'h300, 32'h1111_1111);
    push_ev(K_DACK, 1, 32'h0, 32'h0);
    push_ev(K_RAMW, 0, 32'h304, 32'h2222_2222);
    push_ev(K_DACK, 1, 32'h0, 32'h0);
    set_daddr(1, 32'h300);
    set_dstore(1, 32'h1111_1111);
    dWEN[1] = 1'b1;
    ramstate = 2'd1;
    @(posedge CLK);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t3_busy_wen", 64'(ramWEN), 64'd1);
      chk("t3_busy_dwait", 64'(dwait[1]), 64'd1);
      chk("t3_busy_state", 64'(dbg_state), 64'(S_WB0));
    end
    @(posedge CLK);
    #1 ramstate = 2'd2;
    @(posedge CLK);
    #1 set_dstore(1, 32'h2222_2222);
    @(negedge CLK);
    chk("t3_wb1_state", 64'(dbg_state), 64'(S_WB1));
    @(posedge CLK);
    #1 dWEN = '0;
    chk("t3_rr", 64'(dbg_rr), 64'd2);

    // reset during RD1
    push_ev(K_RAMR, 0, 32'h600, 32'hA000_0600);
    push_ev(K_DACK, 1, 32'h0, 32'hA000_0600);
    set_daddr(1, 32'h600);
    cctrans[1] = 1'b1;
    wait_dacks(1, 1, -1, 32'h0);
    chk("t6_in_rd1", 64'(dbg_state), 64'(S_RD1));
    chk("t6_rd1_addr", 64'(ramaddr), 64'h604);
    #1 nRST = 1'b0;
    #1;
    chk("t6_abort_ram", 64'({ramREN, ramWEN, ramaddr}), 64'h0);
    chk("t6_abort_waits", 64'({iwait, dwait}), 64'hFF);
    chk("t6_abort_dload", 64'((|dload)), 64'h0);
    chk("t6_abort_state", 64'({dbg_state, dbg_rr}), 64'h0);
    cctrans = '0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    chk("t6_after_release", 64'({dbg_state, dbg_rr, ccwait}), 64'h0);

    // all four request continuously: grants 0,1,2,3,0
    for (int g = 0; g < 5; g++) begin
      push_ev(K_RAMR, 0, 32'h400 + 32'(g % 4) * 32'h40, 32'hA000_0400 + 32'(g % 4) * 32'h40);
      push_ev(K_DACK, g % 4, 32'h0, 32'hA000_0400 + 32'(g % 4) * 32'h40);
      push_ev(K_RAMR, 0, 32'h404 + 32'(g % 4) * 32'h40, 32'hA000_0404 + 32'(g % 4) * 32'h40);
      push_ev(K_DACK, g % 4, 32'h0, 32'hA000_0404 + 32'(g % 4) * 32'h40);
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < CPUS; i++) set_daddr(i, 32'h400 + 32'(i) * 32'h40);
    cctrans = 4'b1111;
    begin
      int acks = 0;
      int cyc = 0;
      while (acks < 10 && cyc < 200) begin
        @(negedge CLK);
        cyc++;
        for (int i = 0; i < CPUS; i++) if (!dwait[i]) acks++;
        @(posedge CLK);
        #1;
      end
      chk("t4_acks", 64'(acks), 64'd10);
    end
    cctrans = '0;
    chk("t4_rr", 64'(dbg_rr), 64'd1);

    // data and instruction request on the same CPU: data first
    push_ev(K_RAMR, 0, 32'h500, 32'hA000_0500);
    push_ev(K_DACK, 0, 32'h0, 32'hA000_0500);
    push_ev(K_RAMR, 0, 32'h504, 32'hA000_0504);
    push_ev(K_DACK, 0, 32'h0, 32'hA000_0504);
    push_ev(K_RAMR, 0, 32'h800, 32'hA000_0800);
    push_ev(K_IACK, 0, 32'h0, 32'hA000_0800);
    set_daddr(0, 32'h500);
    iaddr[0 +: ADDR_W] = 32'h800;
    cctrans[0] = 1'b1;
    dREN[0] = 1'b1;
    iREN[0] = 1'b1;
    wait_dacks(0, 2, -1, 32'h0);
    cctrans = '0;
    dREN = '0;
    begin
      int got = 0;
      int cyc = 0;
      while (got == 0 && cyc < 50) begin
        @(negedge CLK);
        cyc++;
        if (!iwait[0]) got = 1;
        @(posedge CLK);
        #1;
      end
      chk("t5_iack", 64'(got), 64'd1);
    end
    iREN = '0;
    chk("t5_rr", 64'(dbg_rr), 64'd1);

    repeat (3) @(posedge CLK);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
